// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu (MDOp 9..12).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;

  logic            is_start, is_div;
  logic [63:0]     prod_s, prod_u, res;
  logic            a_neg, b_neg;
  logic [31:0]     a_mag, b_mag, b_safe_s, b_safe_u;
  logic [31:0]     sq_mag, sr_mag, uq, ur;

  always_comb begin
    is_div = (MDOp == 4'd3) || (MDOp == 4'd4);
`ifdef MD_MADD_EN
    is_start = ((MDOp >= 4'd1) && (MDOp <= 4'd4)) || ((MDOp >= 4'd9) && (MDOp <= 4'd12));
`else
    is_start = (MDOp >= 4'd1) && (MDOp <= 4'd4);
`endif
  end

  assign Busy  = (state_q == S_BUSY);
  assign Start = is_start && !Busy;
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    MDOut = 32'd0;
    if (MDOp == 4'd7)      MDOut = hi_q;
    else if (MDOp == 4'd8) MDOut = lo_q;
  end

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
  always_comb begin
    prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u   = {32'd0, A} * {32'd0, B};
    a_neg    = A[31];
    b_neg    = B[31];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    b_safe_s = (B == 32'd0) ? 32'd1 : b_mag;
    b_safe_u = (B == 32'd0) ? 32'd1 : B;
    sq_mag   = a_mag / b_safe_s;
    sr_mag   = a_mag % b_safe_s;
    uq       = A / b_safe_u;
    ur       = A % b_safe_u;
  end

  always_comb begin
    res = {hi_q, lo_q};
    case (MDOp)
      4'd1: res = prod_s;
      4'd2: res = prod_u;
      4'd3: if (B != 32'd0)
              res = {(a_neg ? -sr_mag : sr_mag), ((a_neg ^ b_neg) ? -sq_mag : sq_mag)};
      4'd4: if (B != 32'd0) res = {ur, uq};
`ifdef MD_MADD_EN
      4'd9:  res = {hi_q, lo_q} + prod_s;
      4'd10: res = {hi_q, lo_q} + prod_u;
      4'd11: res = {hi_q, lo_q} - prod_s;
      4'd12: res = {hi_q, lo_q} - prod_u;
`endif
      default: res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_nxt_d = hi_nxt_q;
    lo_nxt_d = lo_nxt_q;
    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          hi_nxt_d = res[63:32];
          lo_nxt_d = res[31:0];
          cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d  = S_BUSY;
        end else if (MDOp == 4'd5) begin
          hi_d = A;
        end else if (MDOp == 4'd6) begin
          lo_d = A;
        end
      end
      S_BUSY: begin
        // Moves into HI/LO are dropped while busy; the hazard unit stalls them.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = hi_nxt_q;
          lo_d    = lo_nxt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_nxt_q <= 32'd0;
      lo_nxt_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_nxt_q <= hi_nxt_d;
      lo_nxt_q <= lo_nxt_d;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against an arithmetic model of HI/LO.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] MDOut, HI, LO;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B),
    .Start(Start), .Busy(Busy), .MDOut(MDOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? 10 : 5;
  endfunction

  // Reference: what {HI,LO} must become once the op completes.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ps, pu, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = 64'(sa * sb);
    pu  = {32'd0, a} * {32'd0, b};
    acc = {m_hi, m_lo};
    case (op)
      4'd1: acc = ps;
      4'd2: acc = pu;
      4'd3: if (b != 0) acc = {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b != 0) acc = {a % b, a / b};
      4'd9:  acc = acc + ps;
      4'd10: acc = acc + pu;
      4'd11: acc = acc - ps;
      4'd12: acc = acc - pu;
      default: ;
    endcase
    {m_hi, m_lo} = acc;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp = op; A = a; B = b;
    #1;
    chk({tag, "_start"}, 32'(Start), 32'd1);
    model(op, a, b);
    step();
    MDOp = 4'd0; A = $urandom; B = $urandom;
    for (int i = 0; i < lat(op); i++) begin
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      step();
    end
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  task automatic mv(input string tag, input logic [3:0] op, input logic [31:0] a);
    MDOp = op; A = a;
    step();
    MDOp = 4'd0;
    if (op == 4'd5) m_hi = a; else m_lo = a;
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    int          r;

    reset = 1'b1; MDOp = 4'd0; A = 32'd0; B = 32'd0;
    #12;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    reset = 1'b0;
    step();

    run_op("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_neg_hi_c", HI, 32'hFFFFFFFF);
    chk("mult_neg_lo_c", LO, 32'hFFFFFFFA);
    MDOp = 4'd8; #1;
    chk("mflo", MDOut, 32'hFFFFFFFA);
    MDOp = 4'd7; #1;
    chk("mfhi", MDOut, 32'hFFFFFFFF);
    MDOp = 4'd0; #1;
    chk("mdout_none", MDOut, 32'd0);

    run_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi_c", HI, 32'hFFFFFFFE);
    chk("multu_lo_c", LO, 32'h00000001);

    run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_lo_c", LO, 32'hFFFFFFFD);
    chk("div_hi_c", HI, 32'hFFFFFFFF);
    run_op("divu_zero", 4'd4, 32'd7, 32'd0);
    chk("divu_zero_lo_c", LO, 32'hFFFFFFFD);
    chk("divu_zero_hi_c", HI, 32'hFFFFFFFF);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo_c", LO, 32'h80000000);
    chk("div_ovf_hi_c", HI, 32'h00000000);

    // Moves and new starts while busy must be dropped.
    MDOp = 4'd1; A = 32'd3; B = 32'd5; #1;
    chk("mb_start", 32'(Start), 32'd1);
    model(4'd1, 32'd3, 32'd5);
    step();
    MDOp = 4'd5; A = 32'h1234; #1;
    chk("mb_mthi_start", 32'(Start), 32'd0);
    step();
    MDOp = 4'd3; A = 32'd9; B = 32'd2; #1;
    chk("mb_div_start", 32'(Start), 32'd0);
    step();
    MDOp = 4'd0;
    repeat (3) step();
    chk("mb_idle", 32'(Busy), 32'd0);
    chk("mb_hi", HI, 32'd0);
    chk("mb_lo", LO, 32'd15);
    mv("mtlo", 4'd6, 32'h55);
    chk("mtlo_c", LO, 32'h55);

    MDOp = 4'd13; A = 32'hABCD; #1;
    chk("rsv13_mdout", MDOut, 32'd0);
    chk("rsv13_start", 32'(Start), 32'd0);
    step();
    chk("rsv13_lo", LO, m_lo);
`ifndef MD_MADD_EN
    MDOp = 4'd9; #1;
    chk("rsv9_start", 32'(Start), 32'd0);
    step();
    chk("rsv9_hi", HI, m_hi);
    chk("rsv9_busy", 32'(Busy), 32'd0);
`else
    mv("madd_hi0", 4'd5, 32'd0);
    mv("madd_lo1", 4'd6, 32'hFFFFFFFF);
    run_op("maddu", 4'd10, 32'd1, 32'd1);
    chk("maddu_hi_c", HI, 32'd1);
    chk("maddu_lo_c", LO, 32'd0);
    run_op("msub", 4'd11, 32'd1, 32'd1);
    chk("msub_hi_c", HI, 32'd0);
    chk("msub_lo_c", LO, 32'hFFFFFFFF);
`endif
    MDOp = 4'd0;

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if (r < 2) begin
        mv("rnd_mv", (r == 0) ? 4'd5 : 4'd6, ra);
      end else begin
`ifdef MD_MADD_EN
        op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(9, 12));
`else
        op = 4'($urandom_range(1, 4));
`endif
        run_op("rnd_op", op, ra, rb);
      end
    end

    // Async reset in the middle of a divide: cleared at once, nothing commits afterwards.
    mv("pre_rst", 4'd5, 32'hDEAD);
    MDOp = 4'd3; A = 32'd100; B = 32'd7;
    step();
    MDOp = 4'd0;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    #3 reset = 1'b0;
    repeat (12) step();
    chk("arst_post_busy", 32'(Busy), 32'd0);
    chk("arst_post_hi", HI, 32'd0);
    chk("arst_post_lo", LO, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the 5-stage MIPS pipeline. Sits in the E stage beside the ALU.
- Owns the HI/LO registers and sequences mult/multu/div/divu over a fixed latency.
- Exposes Busy/Start so the hazard unit can stall any following md-class instruction in D.
- Services mthi/mtlo/mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high after a multiply is issued (>=1)
- DIV_CYCLES, 10, cycles Busy stays high after a divide is issued (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- MDOp  input  4  decoded E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 reserved
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Start  output  1  combinational: MDOp is 1..4 and Busy=0
- Busy  output  1  registered: an operation is in flight
- MDOut  output  32  combinational: HI when MDOp=7, LO when MDOp=8, else 0
- HI  output  32  architectural HI (debug/trace)
- LO  output  32  architectural LO (debug/trace)

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, Busy=0, counter=0, state IDLE. The pending result is discarded.
- States: IDLE and BUSY.
- IDLE, on a rising edge with Start=1:
  - Latch the operation result into internal HI_nxt/LO_nxt.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Busy<=1; go to BUSY.
- BUSY:
  - Counter decrements every cycle.
  - On the edge where counter goes 1->0: HI<=HI_nxt, LO<=LO_nxt, Busy<=0, back to IDLE.
  - Issue at edge t means Busy is high for cycles t+1..t+N and HI/LO are visible from cycle t+N+1.
- Arithmetic:
  - mult: signed 32x32 to 64; multu: unsigned. {HI,LO} = product.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
  - Divide by B=0: HI/LO keep their old values. Full DIV_CYCLES latency still applies.
  - 32'h80000000 div 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- mthi/mtlo (MDOp 5/6):
  - If Busy=0: HI<=A or LO<=A at the edge.
  - If Busy=1: ignored. The hazard unit must stall them.
- mfhi/mflo (MDOp 7/8): combinational read of the committed HI/LO. While Busy=1 this is stale, and the hazard unit must stall.
- Start ops (1..4) arriving while Busy=1: ignored; Start=0 in that case. The hazard unit guarantees this never reaches E unstalled.
- Reserved MDOp: no effect; MDOut=0.
- Busy and the counter are unaffected by pipeline stalls. The operation runs to completion once issued.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined:
  - MDOp 9 madd, 10 maddu, 11 msub, 12 msubu become start ops with MULT_CYCLES latency.
  - Result: {HI,LO} = {HI,LO} +/- product, using HI/LO as committed at issue; 64-bit wrap on overflow.
  - Start also covers 9..12.
- When undefined: 9..12 are reserved and treated as no-op.

Test Plan:
- reset; MDOp=1, A=32'hFFFFFFFE (-2), B=3 for one cycle -> Busy high 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; MDOut with MDOp=8 reads 32'hFFFFFFFA.
- MDOp=2, A=B=32'hFFFFFFFF -> after 5 cycles HI=32'hFFFFFFFE, LO=32'h00000001.
- MDOp=3, A=-7, B=2 -> Busy 10 cycles; LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). Then MDOp=4, A=7, B=0 -> HI/LO unchanged after 10 cycles.
- Issue mult; during Busy drive MDOp=5, A=32'h1234 and MDOp=3 -> both ignored, Start=0, product committed unchanged. Then MDOp=6, A=32'h55 with Busy=0 -> LO=32'h55 next cycle.
- Issue div; assert reset asynchronously at cycle 4 (between edges) -> Busy, HI, LO go to 0 immediately; no commit occurs later.
- (MD_MADD_EN) HI=0, LO=32'hFFFFFFFF; MDOp=10, A=1, B=1 -> HI=1, LO=0; MDOp=11, A=1, B=1 -> HI=0, LO=32'hFFFFFFFF.
